// File: rtl/gb_act_streamer_if.sv
`default_nettype none
// ============================================================================
// gb_act_streamer_if : activation/flag buffer read ports and PEB channels
// Revision: 1.0
// ============================================================================
interface gb_act_streamer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_ACT    = 16,
  parameter int FLG_WIDTH  = 32,
  parameter int ADDR_WIDTH = 12
);
  localparam int c_WORD_WIDTH = NUM_ACT * DATA_WIDTH;

  logic                    ACTMEM_rd_en;
  logic [ADDR_WIDTH-1:0]   ACTMEM_rd_addr;
  logic [c_WORD_WIDTH-1:0] MEMACT_rd_data;
  logic                    FLGMEM_rd_en;
  logic [ADDR_WIDTH-1:0]   FLGMEM_rd_addr;
  logic [FLG_WIDTH-1:0]    MEMFLG_rd_data;
  logic                    GBACT_Val;
  logic [c_WORD_WIDTH-1:0] GBACT_Data;
  logic                    ACTGB_Rdy;
  logic                    GBFLGACT_val;
  logic [FLG_WIDTH-1:0]    GBFLGACT_data;
  logic                    FLGACTGB_rdy;

  modport master (
    output ACTMEM_rd_en, ACTMEM_rd_addr, FLGMEM_rd_en, FLGMEM_rd_addr,
    output GBACT_Val, GBACT_Data, GBFLGACT_val, GBFLGACT_data,
    input  MEMACT_rd_data, MEMFLG_rd_data, ACTGB_Rdy, FLGACTGB_rdy
  );

  modport slave (
    input  ACTMEM_rd_en, ACTMEM_rd_addr, FLGMEM_rd_en, FLGMEM_rd_addr,
    input  GBACT_Val, GBACT_Data, GBFLGACT_val, GBFLGACT_data,
    output MEMACT_rd_data, MEMFLG_rd_data, ACTGB_Rdy, FLGACTGB_rdy
  );
endinterface
`default_nettype wire

// File: rtl/gb_act_streamer.sv
`default_nettype none
// ============================================================================
// gb_act_streamer : streams activation and flag words from the global buffer
// Revision: 1.0
// ============================================================================
module gb_act_chan #(
  parameter int WIDTH      = 128,
  parameter int ADDR_WIDTH = 12,
  parameter int CNT_WIDTH  = 12
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic                  i_load,
  input  wire logic                  i_run,
  input  wire logic [ADDR_WIDTH-1:0] i_base,
  input  wire logic [CNT_WIDTH-1:0]  i_num,
  output logic                       o_rd_en,
  output logic [ADDR_WIDTH-1:0]      o_rd_addr,
  input  wire logic [WIDTH-1:0]      i_rd_data,
  output logic                       o_val,
  output logic [WIDTH-1:0]           o_data,
  input  wire logic                  i_rdy,
  output logic                       o_complete
);
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [CNT_WIDTH-1:0]  r_num;
  logic [CNT_WIDTH-1:0]  r_issued;
  logic [CNT_WIDTH-1:0]  r_sent;
  logic                  r_pend;
  logic [WIDTH-1:0]      r_mem [2];
  logic                  r_wp;
  logic                  r_rp;
  logic [1:0]            r_cnt;
  logic                  w_pop;
  logic [1:0]            w_occ;

  // Slots already claimed by stored words and the read in flight, net of a pop.
  assign w_pop      = o_val && i_rdy;
  assign w_occ      = r_cnt + {1'b0, r_pend} - {1'b0, w_pop};
  assign o_rd_en    = i_run && (r_issued < r_num) && (w_occ < 2'd2);
  assign o_rd_addr  = r_addr;
  assign o_val      = (r_cnt != 2'd0);
  assign o_data     = r_mem[r_rp];
  assign o_complete = (r_sent == r_num);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr   <= '0;
      r_num    <= '0;
      r_issued <= '0;
      r_sent   <= '0;
      r_pend   <= 1'b0;
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_cnt    <= 2'd0;
    end else if (i_load) begin
      r_addr   <= i_base;
      r_num    <= i_num;
      r_issued <= '0;
      r_sent   <= '0;
      r_pend   <= 1'b0;
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      r_pend <= o_rd_en;
      if (o_rd_en) begin
        r_addr   <= r_addr + 1'b1;
        r_issued <= r_issued + 1'b1;
      end
      if (r_pend) begin
        r_mem[r_wp] <= i_rd_data;
        r_wp        <= ~r_wp;
      end
      if (w_pop) begin
        r_rp   <= ~r_rp;
        r_sent <= r_sent + 1'b1;
      end
      r_cnt <= r_cnt + {1'b0, r_pend} - {1'b0, w_pop};
    end
  end
endmodule

module gb_act_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_ACT    = 16,
  parameter int FLG_WIDTH  = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int CNT_WIDTH  = 12
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic                  CCUACT_start,
  input  wire logic [ADDR_WIDTH-1:0] CFG_act_base,
  input  wire logic [CNT_WIDTH-1:0]  CFG_act_num,
  input  wire logic [ADDR_WIDTH-1:0] CFG_flg_base,
  input  wire logic [CNT_WIDTH-1:0]  CFG_flg_num,
  output logic                       ACTCCU_busy,
  output logic                       ACTCCU_done,
  gb_act_streamer_if.master          bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_load;
  logic   w_run;
  logic   w_act_cmp;
  logic   w_flg_cmp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: if (CCUACT_start) begin
        w_state_nxt = S_RUN;
        w_load      = 1'b1;
      end
      S_RUN:  if (w_act_cmp && w_flg_cmp) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_run       = (r_state == S_RUN);
  assign ACTCCU_busy = (r_state != S_IDLE);
  assign ACTCCU_done = (r_state == S_DONE);

  gb_act_chan #(
    .WIDTH(NUM_ACT * DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .CNT_WIDTH(CNT_WIDTH)
  ) u_act (
    .clk(clk), .rst_n(rst_n), .i_load(w_load), .i_run(w_run),
    .i_base(CFG_act_base), .i_num(CFG_act_num),
    .o_rd_en(bus.ACTMEM_rd_en), .o_rd_addr(bus.ACTMEM_rd_addr),
    .i_rd_data(bus.MEMACT_rd_data),
    .o_val(bus.GBACT_Val), .o_data(bus.GBACT_Data), .i_rdy(bus.ACTGB_Rdy),
    .o_complete(w_act_cmp)
  );

  gb_act_chan #(
    .WIDTH(FLG_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .CNT_WIDTH(CNT_WIDTH)
  ) u_flg (
    .clk(clk), .rst_n(rst_n), .i_load(w_load), .i_run(w_run),
    .i_base(CFG_flg_base), .i_num(CFG_flg_num),
    .o_rd_en(bus.FLGMEM_rd_en), .o_rd_addr(bus.FLGMEM_rd_addr),
    .i_rd_data(bus.MEMFLG_rd_data),
    .o_val(bus.GBFLGACT_val), .o_data(bus.GBFLGACT_data), .i_rdy(bus.FLGACTGB_rdy),
    .o_complete(w_flg_cmp)
  );
endmodule
`default_nettype wire

// File: tb/tb_gb_act_streamer.sv
`default_nettype none
// ============================================================================
// tb_gb_act_streamer : randomized scoreboard bench for gb_act_streamer
// Revision: 1.0
// ============================================================================
module tb_gb_act_streamer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        CCUACT_start = 1'b0;
  logic [11:0] CFG_act_base = '0, CFG_flg_base = '0;
  logic [11:0] CFG_act_num = '0, CFG_flg_num = '0;
  logic        ACTCCU_busy, ACTCCU_done;

  gb_act_streamer_if bus ();

  gb_act_streamer dut (
    .clk(clk), .rst_n(rst_n), .CCUACT_start(CCUACT_start),
    .CFG_act_base(CFG_act_base), .CFG_act_num(CFG_act_num),
    .CFG_flg_base(CFG_flg_base), .CFG_flg_num(CFG_flg_num),
    .ACTCCU_busy(ACTCCU_busy), .ACTCCU_done(ACTCCU_done), .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_err = 0, n_done = 0;
  int start_cyc = 0, last_hs = 0, first_a = -1, first_f = -1, done_cyc = -1;
  int act_out = 0, flg_out = 0, rdy_mode = 0;
  logic [127:0] exp_act_data[$];
  logic [31:0]  exp_flg_data[$];
  logic [11:0]  exp_act_addr[$], exp_flg_addr[$];

  function automatic logic [127:0] act_word(input logic [11:0] a);
    logic [127:0] w;
    for (int k = 0; k < 4; k++)
      w[k*32 +: 32] = ({20'd0, a} + 32'd1) * 32'h9E3779B1 ^ (k * 32'h85EBCA6B);
    return w;
  endfunction

  function automatic logic [31:0] flg_word(input logic [11:0] a);
    return ({20'd0, a} * 32'hC2B2AE35) ^ 32'h5A5A1234;
  endfunction

  // Buffer model: one-cycle read latency, junk on idle cycles.
  always @(posedge clk) begin
    bus.MEMACT_rd_data <= bus.ACTMEM_rd_en ? act_word(bus.ACTMEM_rd_addr)
                                           : {$urandom, $urandom, $urandom, $urandom};
    bus.MEMFLG_rd_data <= bus.FLGMEM_rd_en ? flg_word(bus.FLGMEM_rd_addr) : $urandom;
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: begin bus.ACTGB_Rdy = 1'b1; bus.FLGACTGB_rdy = 1'b1; end
      1: begin
        bus.ACTGB_Rdy    = ($urandom_range(0, 3) != 0);
        bus.FLGACTGB_rdy = ($urandom_range(0, 2) != 0);
      end
      default: begin
        bus.ACTGB_Rdy    = !((cyc - start_cyc) >= 3 && (cyc - start_cyc) <= 7);
        bus.FLGACTGB_rdy = 1'b1;
      end
    endcase
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  logic         stall_a = 1'b0, stall_f = 1'b0, prev_done = 1'b0;
  logic [127:0] hold_a;
  logic [31:0]  hold_f;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_a = 1'b0; stall_f = 1'b0; prev_done = 1'b0;
    end else begin
      if (bus.GBACT_Val) begin
        if (stall_a) chk("act_hold_data", bus.GBACT_Data, hold_a);
        if (first_a < 0) first_a = cyc;
        if (bus.ACTGB_Rdy) begin
          if (exp_act_data.size() == 0) chk("act_val_unexpected", 1, 0);
          else chk("act_data", bus.GBACT_Data, exp_act_data.pop_front());
          act_out--; last_hs = cyc;
        end
      end else if (stall_a) chk("act_hold_val", 0, 1);
      stall_a = bus.GBACT_Val && !bus.ACTGB_Rdy;
      hold_a  = bus.GBACT_Data;

      if (bus.GBFLGACT_val) begin
        if (stall_f) chk("flg_hold_data", {96'd0, bus.GBFLGACT_data}, {96'd0, hold_f});
        if (first_f < 0) first_f = cyc;
        if (bus.FLGACTGB_rdy) begin
          if (exp_flg_data.size() == 0) chk("flg_val_unexpected", 1, 0);
          else chk("flg_data", {96'd0, bus.GBFLGACT_data}, {96'd0, exp_flg_data.pop_front()});
          flg_out--; last_hs = cyc;
        end
      end else if (stall_f) chk("flg_hold_val", 0, 1);
      stall_f = bus.GBFLGACT_val && !bus.FLGACTGB_rdy;
      hold_f  = bus.GBFLGACT_data;

      if (bus.ACTMEM_rd_en) begin
        if (exp_act_addr.size() == 0) chk("act_rd_unexpected", 1, 0);
        else chk("act_rd_addr", {116'd0, bus.ACTMEM_rd_addr}, {116'd0, exp_act_addr.pop_front()});
        act_out++;
        chk("act_outstanding_le2", act_out <= 2, 1);
      end
      if (bus.FLGMEM_rd_en) begin
        if (exp_flg_addr.size() == 0) chk("flg_rd_unexpected", 1, 0);
        else chk("flg_rd_addr", {116'd0, bus.FLGMEM_rd_addr}, {116'd0, exp_flg_addr.pop_front()});
        flg_out++;
        chk("flg_outstanding_le2", flg_out <= 2, 1);
      end

      if (ACTCCU_done) begin
        chk("done_single_cycle", prev_done, 0);
        chk("done_cycle", cyc, last_hs + 2);
        chk("done_drained", exp_act_data.size() + exp_flg_data.size(), 0);
        chk("busy_at_done", ACTCCU_busy, 1);
        done_cyc = cyc;
        n_done++;
      end
      prev_done = ACTCCU_done;
    end
  end

  task automatic flush();
    exp_act_data.delete(); exp_flg_data.delete();
    exp_act_addr.delete(); exp_flg_addr.delete();
    act_out = 0; flg_out = 0;
  endtask

  task automatic start_xfer(input logic [11:0] ab, input int an, input logic [11:0] fb, input int fn);
    for (int i = 0; i < an; i++) begin
      logic [11:0] a;
      a = ab + 12'(i);
      exp_act_addr.push_back(a);
      exp_act_data.push_back(act_word(a));
    end
    for (int i = 0; i < fn; i++) begin
      logic [11:0] a;
      a = fb + 12'(i);
      exp_flg_addr.push_back(a);
      exp_flg_data.push_back(flg_word(a));
    end
    CFG_act_base = ab; CFG_act_num = 12'(an);
    CFG_flg_base = fb; CFG_flg_num = 12'(fn);
    start_cyc = cyc; last_hs = cyc; first_a = -1; first_f = -1; done_cyc = -1;
    CCUACT_start = 1'b1;
    @(posedge clk); #1;
    CCUACT_start = 1'b0;
    CFG_act_base = 12'($urandom); CFG_act_num = 12'($urandom);
    CFG_flg_base = 12'($urandom); CFG_flg_num = 12'($urandom);
  endtask

  task automatic wait_done(input int budget);
    int n0 = n_done;
    int k = 0;
    while (n_done == n0 && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    if (n_done == n0) chk("done_timeout", 0, 1);
    chk("busy_low_after_done", ACTCCU_busy, 0);
  endtask

  task automatic chk_outputs_zero(input string nm);
    chk(nm, {bus.ACTMEM_rd_en, bus.FLGMEM_rd_en, bus.GBACT_Val, bus.GBFLGACT_val,
             ACTCCU_busy, ACTCCU_done, bus.ACTMEM_rd_addr, bus.FLGMEM_rd_addr}, 0);
    chk({nm, "_data"}, bus.GBACT_Data | {96'd0, bus.GBFLGACT_data}, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n0;
    bus.ACTGB_Rdy = 1'b1; bus.FLGACTGB_rdy = 1'b1;
    #12;
    chk_outputs_zero("reset_outputs");
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // Back-to-back streaming latency.
    rdy_mode = 0;
    start_xfer(12'd100, 4, 12'd200, 2);
    chk("busy_after_start", ACTCCU_busy, 1);
    wait_done(40);
    chk("first_act_val_cycle", first_a, start_cyc + 3);
    chk("first_flg_val_cycle", first_f, start_cyc + 3);
    chk("done_latency_4_2", done_cyc, start_cyc + 8);

    // Backpressure on the activation channel.
    rdy_mode = 2;
    start_xfer(12'd300, 3, 12'd50, 1);
    wait_done(60);

    // Empty group.
    rdy_mode = 0;
    start_xfer(12'd7, 0, 12'd9, 0);
    chk("busy_empty_cycle1", ACTCCU_busy, 1);
    wait_done(10);
    chk("done_latency_empty", done_cyc, start_cyc + 2);
    chk("no_val_empty", {first_a == -1, first_f == -1}, 2'b11);

    // Address wrap.
    start_xfer(12'd4094, 4, 12'd4095, 3);
    wait_done(40);

    // Restart and CFG change during RUN are ignored.
    n0 = n_done;
    rdy_mode = 1;
    start_xfer(12'd500, 6, 12'd600, 5);
    repeat (2) begin @(posedge clk); #1; end
    CFG_act_base = 12'd1; CFG_act_num = 12'd9; CCUACT_start = 1'b1;
    @(posedge clk); #1; CCUACT_start = 1'b0;
    wait_done(100);
    repeat (10) begin @(posedge clk); #1; end
    chk("single_done_on_restart", n_done - n0, 1);

    // Abort by reset in the middle of a transfer.
    rdy_mode = 0;
    start_xfer(12'd1000, 10, 12'd2000, 10);
    repeat (4) begin @(posedge clk); #1; end
    #2; rst_n = 1'b0; #1;
    chk_outputs_zero("abort_outputs");
    flush();
    n0 = n_done;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    chk("no_done_after_abort", n_done - n0, 0);
    start_xfer(12'd1000, 10, 12'd2000, 10);
    wait_done(60);

    // Maximum word count.
    rdy_mode = 1;
    start_xfer(12'd3000, 4095, 12'd10, 3);
    wait_done(20000);

    for (int t = 0; t < 25; t++) begin
      rdy_mode = $urandom_range(0, 1);
      start_xfer(12'($urandom), $urandom_range(0, 12), 12'($urandom), $urandom_range(0, 12));
      wait_done(200);
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
